// File: rtl/awp_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// awp_bus_arb_pkg
// Shared definitions for the CPU/AWP system-interface arbiter:
//   - arb_state_e : 2-bit arbiter state encoding (IDLE/GNT_CPU/GNT_FP/RELEASE)
//   - owner_e     : encoding of the requester that last held the interface
//   - DEF_TIMEOUT_TICKS : default no-answer timeout in clock cycles
// -----------------------------------------------------------------------------
package awp_bus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GNT_CPU = 2'd1,
      ST_GNT_FP  = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_FP  = 1'b1
   } owner_e;

   localparam int unsigned DEF_TIMEOUT_TICKS = 200;

endpackage

// File: rtl/awp_bus_arb_timer.sv
// -----------------------------------------------------------------------------
// arb_timer
// No-answer timer for awp_bus_arb. A CW-bit counter that is cleared when a
// grant is issued and counts every granted cycle without an interface answer.
// It saturates at all-ones and never wraps.
// The module is only compiled when AWP_ARB_TIMEOUT_EN is defined, which is
// also the only build that instantiates it; otherwise it would be an
// unreferenced top-level module.
//
// Ports:
//   clk     in  : system clock
//   rst     in  : synchronous active-high reset
//   clr     in  : clear the counter (grant being issued this cycle)
//   inc     in  : count this cycle (granted, no answer)
//   expired out : the edge ending this cycle is edge TIMEOUT_TICKS after grant
// -----------------------------------------------------------------------------
`ifdef AWP_ARB_TIMEOUT_EN
module arb_timer
   import awp_bus_arb_pkg::*;
#(
   parameter int unsigned   CW            = 8,
   parameter logic [CW-1:0] TIMEOUT_TICKS = CW'(DEF_TIMEOUT_TICKS)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW:0]   cnt_after_edge;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // The counter holds the number of answerless edges already seen since the
   // grant, so the edge closing the current cycle is number cnt_q + 1.
   // Computed one bit wider so a saturated counter still compares as expired.
   assign cnt_after_edge = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
   assign expired        = (cnt_after_edge >= {1'b0, TIMEOUT_TICKS});

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/awp_bus_arb.sv
// -----------------------------------------------------------------------------
// awp_bus_arb
// Two-requester arbiter sharing the system-interface master port between the
// CPU control unit and the AWP (FPU control) unit. One requester at a time is
// granted; the arbiter drives the single registered interface request, routes
// the interface answer back to the owner as one-cycle pulses and, when built
// with AWP_ARB_TIMEOUT_EN defined, times out transfers that get no answer.
// Without AWP_ARB_TIMEOUT_EN no timer exists, no_cpu/no_fp stay 0 and a grant
// waits indefinitely for an answer.
//
// Parameters:
//   CW            : timeout counter width
//   TIMEOUT_TICKS : answerless cycles before a no-answer pulse (< 2^CW)
// Ports:
//   clk_sys in  : system clock
//   rst     in  : synchronous active-high reset
//   sr_cpu  in  : CPU request (level, held until answered)
//   rd_cpu  in  : CPU transfer is a read
//   sr_fp   in  : AWP request (level, held until answered)
//   rd_fp   in  : AWP transfer is a read
//   bus_ok  in  : interface answer, transfer accepted
//   bus_en  in  : interface answer, transfer refused (engaged)
//   bus_sr  out : registered interface request
//   bus_rd  out : registered read qualifier of the current owner
//   grant_cpu/grant_fp out : owner indication, held through RELEASE
//   ok_cpu/en_cpu/no_cpu   out : CPU accepted / refused / timed-out pulses
//   ok_fp/en_fp/no_fp      out : AWP accepted / refused / timed-out pulses
//   busy    out : arbiter is not IDLE
// -----------------------------------------------------------------------------
module awp_bus_arb
   import awp_bus_arb_pkg::*;
#(
   parameter int unsigned   CW            = 8,
   parameter logic [CW-1:0] TIMEOUT_TICKS = CW'(DEF_TIMEOUT_TICKS)
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic sr_cpu,
   input  logic rd_cpu,
   input  logic sr_fp,
   input  logic rd_fp,
   input  logic bus_ok,
   input  logic bus_en,
   output logic bus_sr,
   output logic bus_rd,
   output logic grant_cpu,
   output logic grant_fp,
   output logic ok_cpu,
   output logic en_cpu,
   output logic ok_fp,
   output logic en_fp,
   output logic no_cpu,
   output logic no_fp,
   output logic busy
);

   arb_state_e state_q, state_d;
   owner_e     last_owner_q, last_owner_d;

   logic bus_sr_q, bus_sr_d;
   logic bus_rd_q, bus_rd_d;
   logic grant_cpu_q, grant_cpu_d;
   logic grant_fp_q, grant_fp_d;
   logic ok_cpu_q, ok_cpu_d;
   logic en_cpu_q, en_cpu_d;
   logic no_cpu_q, no_cpu_d;
   logic ok_fp_q, ok_fp_d;
   logic en_fp_q, en_fp_d;
   logic no_fp_q, no_fp_d;

   logic answered;
   logic timed_out;
   logic tmr_clr;
   logic tmr_inc;
   logic owner_sr;
   logic fp_wins_tie;

   assign answered    = bus_ok | bus_en;
   assign owner_sr    = (last_owner_q == OWN_CPU) ? sr_cpu : sr_fp;
   // On a tie the requester that did not own the interface last goes first,
   // so neither side is granted twice in a row while the other waits.
   assign fp_wins_tie = sr_fp && (last_owner_q == OWN_CPU);

`ifdef AWP_ARB_TIMEOUT_EN
   arb_timer #(
      .CW            (CW),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) u_timer (
      .clk     (clk_sys),
      .rst     (rst),
      .clr     (tmr_clr),
      .inc     (tmr_inc),
      .expired (timed_out)
   );
`else
   assign timed_out = 1'b0;
   // Timer controls and the timeout value have no consumer in this build;
   // the parameter stays so both builds share one instantiation interface.
   logic unused_timer_cfg;
   assign unused_timer_cfg = ^{tmr_clr, tmr_inc, TIMEOUT_TICKS};
`endif

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      bus_sr_d     = bus_sr_q;
      bus_rd_d     = bus_rd_q;
      grant_cpu_d  = grant_cpu_q;
      grant_fp_d   = grant_fp_q;
      ok_cpu_d     = 1'b0;
      en_cpu_d     = 1'b0;
      no_cpu_d     = 1'b0;
      ok_fp_d      = 1'b0;
      en_fp_d      = 1'b0;
      no_fp_d      = 1'b0;
      tmr_clr      = 1'b0;
      tmr_inc      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sr_cpu && !fp_wins_tie) begin
               state_d      = ST_GNT_CPU;
               last_owner_d = OWN_CPU;
               bus_sr_d     = 1'b1;
               bus_rd_d     = rd_cpu;
               grant_cpu_d  = 1'b1;
               tmr_clr      = 1'b1;
            end else if (sr_fp) begin
               state_d      = ST_GNT_FP;
               last_owner_d = OWN_FP;
               bus_sr_d     = 1'b1;
               bus_rd_d     = rd_fp;
               grant_fp_d   = 1'b1;
               tmr_clr      = 1'b1;
            end
         end

         // The owner's request is deliberately not looked at while granted:
         // a withdrawn request still runs to an answer or a timeout.
         ST_GNT_CPU: begin
            if (bus_en) begin
               en_cpu_d = 1'b1;
            end else if (bus_ok) begin
               ok_cpu_d = 1'b1;
            end else if (timed_out) begin
               no_cpu_d = 1'b1;
            end
            if (answered || timed_out) begin
               bus_sr_d = 1'b0;
               bus_rd_d = 1'b0;
               state_d  = ST_RELEASE;
            end else begin
               tmr_inc = 1'b1;
            end
         end

         ST_GNT_FP: begin
            if (bus_en) begin
               en_fp_d = 1'b1;
            end else if (bus_ok) begin
               ok_fp_d = 1'b1;
            end else if (timed_out) begin
               no_fp_d = 1'b1;
            end
            if (answered || timed_out) begin
               bus_sr_d = 1'b0;
               bus_rd_d = 1'b0;
               state_d  = ST_RELEASE;
            end else begin
               tmr_inc = 1'b1;
            end
         end

         ST_RELEASE: begin
            // last_owner still names the requester that was just served.
            if (!owner_sr) begin
               state_d     = ST_IDLE;
               grant_cpu_d = 1'b0;
               grant_fp_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_owner_q <= OWN_FP;
         bus_sr_q     <= 1'b0;
         bus_rd_q     <= 1'b0;
         grant_cpu_q  <= 1'b0;
         grant_fp_q   <= 1'b0;
         ok_cpu_q     <= 1'b0;
         en_cpu_q     <= 1'b0;
         no_cpu_q     <= 1'b0;
         ok_fp_q      <= 1'b0;
         en_fp_q      <= 1'b0;
         no_fp_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         bus_sr_q     <= bus_sr_d;
         bus_rd_q     <= bus_rd_d;
         grant_cpu_q  <= grant_cpu_d;
         grant_fp_q   <= grant_fp_d;
         ok_cpu_q     <= ok_cpu_d;
         en_cpu_q     <= en_cpu_d;
         no_cpu_q     <= no_cpu_d;
         ok_fp_q      <= ok_fp_d;
         en_fp_q      <= en_fp_d;
         no_fp_q      <= no_fp_d;
      end
   end

   assign bus_sr    = bus_sr_q;
   assign bus_rd    = bus_rd_q;
   assign grant_cpu = grant_cpu_q;
   assign grant_fp  = grant_fp_q;
   assign ok_cpu    = ok_cpu_q;
   assign en_cpu    = en_cpu_q;
   assign no_cpu    = no_cpu_q;
   assign ok_fp     = ok_fp_q;
   assign en_fp     = en_fp_q;
   assign no_fp     = no_fp_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
